// File: rtl/cache_ro_multi.sv
// Read-only set-associative block cache with FIFO replacement per set.
// One request per cycle; lookup result or fill echo is registered (latency 1).
module cache_ro_multi #(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL  = 24,
  parameter int BIT_INDEX  = 5,
  parameter int WAY        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wrt,
  input  logic [BIT_TOTAL-1:0]  i_addr,
  input  logic [SIZE_BLOCK-1:0] i_data,
  output logic [SIZE_BLOCK-1:0] o_data,
  output logic                  o_success
);

  localparam int SETS  = 1 << BIT_INDEX;
  localparam int TAG_W = BIT_TOTAL - BIT_INDEX;
  localparam int WAY_W = (WAY > 1) ? $clog2(WAY) : 1;

  logic [WAY-1:0]        valid_q [SETS];
  logic [WAY-1:0]        valid_d [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAY];
  logic [TAG_W-1:0]      tag_d   [SETS][WAY];
  logic [SIZE_BLOCK-1:0] data_q  [SETS][WAY];
  logic [SIZE_BLOCK-1:0] data_d  [SETS][WAY];
  logic [WAY_W-1:0]      ptr_q   [SETS];
  logic [WAY_W-1:0]      ptr_d   [SETS];
  logic [SIZE_BLOCK-1:0] o_data_q;
  logic [SIZE_BLOCK-1:0] o_data_d;
  logic                  o_success_q;
  logic                  o_success_d;

  logic [BIT_INDEX-1:0]  index_s;
  logic [TAG_W-1:0]      tag_s;
  logic [WAY-1:0]        hit_vec_s;
  logic                  hit_s;
  logic                  full_s;
  logic [WAY_W-1:0]      hit_way_s;
  logic [WAY_W-1:0]      free_way_s;
  logic [WAY_W-1:0]      victim_s;
  logic [WAY_W-1:0]      ptr_next_s;
  logic [SIZE_BLOCK-1:0] hit_data_s;

  assign index_s   = i_addr[BIT_INDEX-1:0];
  assign tag_s     = i_addr[BIT_TOTAL-1:BIT_INDEX];
  assign o_data    = o_data_q;
  assign o_success = o_success_q;

  // Tag match across the addressed set; descending scan so the lowest way wins.
  always_comb begin
    hit_vec_s  = '0;
    hit_data_s = '0;
    hit_way_s  = '0;
    free_way_s = '0;
    for (int w = WAY - 1; w >= 0; w--) begin
      hit_vec_s[w] = valid_q[index_s][w] && (tag_q[index_s][w] == tag_s);
      hit_data_s   = hit_data_s | (hit_vec_s[w] ? data_q[index_s][w] : '0);
      hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
      free_way_s   = valid_q[index_s][w] ? free_way_s : WAY_W'(w);
    end
    hit_s  = |hit_vec_s;
    full_s = &valid_q[index_s];
  end

  // Way selection for a fill and the wrapping FIFO pointer advance.
  always_comb begin
    victim_s   = hit_s ? hit_way_s : (full_s ? ptr_q[index_s] : free_way_s);
    ptr_next_s = (ptr_q[index_s] == WAY_W'(WAY - 1)) ? WAY_W'(0)
                                                     : ptr_q[index_s] + WAY_W'(1);
  end

  // Next state of cache contents, replacement pointers and response.
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    o_data_d    = o_data_q;
    o_success_d = 1'b0;
    if (en && wrt) begin
      valid_d[index_s][victim_s] = 1'b1;
      tag_d[index_s][victim_s]   = tag_s;
      data_d[index_s][victim_s]  = i_data;
      // Only an eviction from a full set moves the pointer.
      if (!hit_s && full_s) begin
        ptr_d[index_s] = ptr_next_s;
      end else begin
        ptr_d[index_s] = ptr_q[index_s];
      end
      o_data_d    = i_data;
      o_success_d = 1'b1;
    end else if (en) begin
      o_data_d    = hit_s ? hit_data_s : '0;
      o_success_d = hit_s;
    end else begin
      o_data_d    = o_data_q;
      o_success_d = 1'b0;
    end
  end

  // Control state and registered response; reset drops any coincident request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      o_data_q    <= '0;
      o_success_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ptr_q       <= ptr_d;
      o_data_q    <= o_data_d;
      o_success_q <= o_success_d;
    end
  end

  // Tag and data storage; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_cache_ro_multi.sv
// Bench for cache_ro_multi: directed vector table, hand sequences, and random
// traffic checked against a FIFO-ordered reference model (WAY=3 and WAY=1).
module tb_cache_ro_multi;

  logic        clk = 1'b0;
  logic        rst, en, wrt;
  logic [23:0] i_addr;
  logic [31:0] i_data;
  logic [31:0] o_data3, o_data1;
  logic        o_succ3, o_succ1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_ro_multi #(.SIZE_BLOCK(32), .BIT_TOTAL(24), .BIT_INDEX(5), .WAY(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .wrt(wrt), .i_addr(i_addr), .i_data(i_data),
    .o_data(o_data3), .o_success(o_succ3));

  cache_ro_multi #(.SIZE_BLOCK(32), .BIT_TOTAL(24), .BIT_INDEX(5), .WAY(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .wrt(wrt), .i_addr(i_addr), .i_data(i_data),
    .o_data(o_data1), .o_success(o_succ1));

  // Reference model: each set is a list ordered oldest-first (index 0 = oldest).
  logic [18:0] mtag [2][32][3];
  logic [31:0] mdat [2][32][3];
  int          mcnt [2][32];
  logic [31:0] mod  [2];
  logic        ms   [2];

  task automatic model_step(input int m, input logic r, input logic e, input logic w,
                            input logic [23:0] a, input logic [31:0] d);
    int ways, s, h;
    logic [18:0] t;
    ways = (m == 0) ? 3 : 1;
    s = int'(a[4:0]);
    t = a[23:5];
    h = -1;
    if (r) begin
      for (int k = 0; k < 32; k++) mcnt[m][k] = 0;
      mod[m] = 32'h0;
      ms[m]  = 1'b0;
    end else if (!e) begin
      ms[m] = 1'b0;
    end else begin
      for (int k = 0; k < mcnt[m][s]; k++)
        if (mtag[m][s][k] == t) h = k;
      if (w) begin
        ms[m]  = 1'b1;
        mod[m] = d;
        if (h >= 0) begin
          mdat[m][s][h] = d;
        end else if (mcnt[m][s] < ways) begin
          mtag[m][s][mcnt[m][s]] = t;
          mdat[m][s][mcnt[m][s]] = d;
          mcnt[m][s]++;
        end else begin
          for (int k = 0; k < ways - 1; k++) begin
            mtag[m][s][k] = mtag[m][s][k+1];
            mdat[m][s][k] = mdat[m][s][k+1];
          end
          mtag[m][s][ways-1] = t;
          mdat[m][s][ways-1] = d;
        end
      end else if (h >= 0) begin
        ms[m]  = 1'b1;
        mod[m] = mdat[m][s][h];
      end else begin
        ms[m]  = 1'b0;
        mod[m] = 32'h0;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w,
                      input logic [23:0] a, input logic [31:0] d);
    rst = r; en = e; wrt = w; i_addr = a; i_data = d;
    @(posedge clk);
    model_step(0, r, e, w, a, d);
    model_step(1, r, e, w, a, d);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_w3_succ"}, 32'(o_succ3), 32'(ms[0]));
    chk({tag, "_w3_data"}, o_data3, mod[0]);
    chk({tag, "_w1_succ"}, 32'(o_succ1), 32'(ms[1]));
    chk({tag, "_w1_data"}, o_data1, mod[1]);
  endtask

  typedef struct {
    logic        r, e, w;
    logic [23:0] a;
    logic [31:0] d;
    logic        es;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic w, input logic [23:0] a,
                     input logic [31:0] d, input logic es, input logic [31:0] ed);
    vec_t v;
    v.r = r; v.e = e; v.w = w; v.a = a; v.d = d; v.es = es; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    int pool[6];
    logic [23:0] a;
    pool = '{0, 1, 2, 3, 4, 32'h40000};
    rst = 1'b1; en = 1'b0; wrt = 1'b0; i_addr = 24'h0; i_data = 32'h0;

    // Directed table for WAY=3 (r, en, wrt, addr, data, exp_success, exp_data)
    add(0,1,0,  3, 32'h0, 0, 32'h0);
    add(0,1,1,  3, 32'hA, 1, 32'hA);  add(0,1,0,  3, 32'h0, 1, 32'hA);
    add(0,1,1,  4, 32'hB, 1, 32'hB);  add(0,1,0,  4, 32'h0, 1, 32'hB);
    add(0,1,1,  5, 32'hC, 1, 32'hC);  add(0,1,0,  5, 32'h0, 1, 32'hC);
    add(0,1,1,  0, 32'hE, 1, 32'hE);  add(0,1,0,  0, 32'h0, 1, 32'hE);
    add(0,1,1, 32, 32'h1, 1, 32'h1);  add(0,1,1, 64, 32'h2, 1, 32'h2);
    add(0,1,0,  0, 32'h0, 1, 32'hE);  add(0,1,0, 32, 32'h0, 1, 32'h1);
    add(0,1,0, 64, 32'h0, 1, 32'h2);
    add(0,1,1, 96, 32'h3, 1, 32'h3);  add(0,1,0, 96, 32'h0, 1, 32'h3);
    add(0,1,0,  0, 32'h0, 0, 32'h0);
    add(0,1,1, 64, 32'h2, 1, 32'h2);  add(0,1,0, 32, 32'h0, 1, 32'h1);
    add(0,1,1,128, 32'h4, 1, 32'h4);  add(0,1,0, 32, 32'h0, 0, 32'h0);
    add(0,1,0,128, 32'h0, 1, 32'h4);
    add(0,1,1,256, 32'h8, 1, 32'h8);  add(0,1,0, 64, 32'h0, 0, 32'h0);
    add(0,1,0, 96, 32'h0, 1, 32'h3);  add(0,1,0,128, 32'h0, 1, 32'h4);
    add(0,1,0,256, 32'h0, 1, 32'h8);
    add(0,0,1, 17, 32'h99, 0, 32'h8);
    add(0,1,0,  5, 32'h0, 1, 32'hC);  add(0,0,0,  5, 32'h0, 0, 32'hC);
    add(1,1,1,  7, 32'h55, 0, 32'h0);
    add(0,1,0,  7, 32'h0, 0, 32'h0);  add(0,1,0, 96, 32'h0, 0, 32'h0);
    add(0,1,0,  3, 32'h0, 0, 32'h0);

    repeat (5) step(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);
    chk("reset_succ", 32'(o_succ3), 32'h0);
    chk("reset_data", o_data3, 32'h0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_succ", i), 32'(o_succ3), 32'(tbl[i].es));
      chk($sformatf("vec%0d_data", i), o_data3, tbl[i].ed);
      chk_model($sformatf("vec%0d", i));
    end

    // Direct-mapped replacement and full-width tag aliasing
    step(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 24'd64, 32'h2);
    step(1'b0, 1'b1, 1'b1, 24'd96, 32'h3);
    step(1'b0, 1'b1, 1'b0, 24'd64, 32'h0);
    chk("w1_evict_succ", 32'(o_succ1), 32'h0);
    chk("w1_evict_data", o_data1, 32'h0);
    chk("w3_keep_data", o_data3, 32'h2);
    step(1'b0, 1'b1, 1'b0, 24'd96, 32'h0);
    chk("w1_new_succ", 32'(o_succ1), 32'h1);
    chk("w1_new_data", o_data1, 32'h3);
    step(1'b0, 1'b1, 1'b1, 24'h800000, 32'h77);
    step(1'b0, 1'b1, 1'b0, 24'h000000, 32'h0);
    chk("alias_miss_succ", 32'(o_succ3), 32'h0);
    step(1'b0, 1'b1, 1'b0, 24'h800000, 32'h0);
    chk("alias_hit_data", o_data3, 32'h77);
    chk_model("hand");

    // Random traffic over a few sets and a small tag pool
    step(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      a = {19'(pool[$urandom_range(0, 5)]), 5'($urandom_range(0, 3))};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 4), a, $urandom);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_ro_multi.md
# cache_ro_multi

Read-only, set-associative block cache sitting between a ray-tracing data consumer and the slower backing memory. The consumer issues single-cycle lookups; on a miss it fetches the block itself and installs it with a fill request. Both sides share one port, and the cache never writes back. A direct-mapped variant, `cache_ro`, has the identical port list and behaves exactly as this block with `WAY = 1`.

## Interface
- `SIZE_BLOCK`, default 32: block (data word) width in bits.
- `BIT_TOTAL`, default 24: address width. Requires `BIT_TOTAL > BIT_INDEX`.
- `BIT_INDEX`, default 5: set-index width, giving 2^BIT_INDEX sets.
- `WAY`, default 3: blocks per set. Must be ≥ 1 and need not be a power of two.
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: request valid for this cycle.
- `wrt` in 1: when 1 the request is a fill; when 0 it is a lookup. Ignored when `en` = 0.
- `i_addr` in BIT_TOTAL: block address.
- `i_data` in SIZE_BLOCK: fill data.
- `o_data` out SIZE_BLOCK: lookup result or fill echo.
- `o_success` out 1: hit or fill-accepted flag.

## Operation
- Address split:
  - index = `i_addr[BIT_INDEX-1:0]`.
  - tag = `i_addr[BIT_TOTAL-1:BIT_INDEX]`.
- Per-set state:
  - `WAY` entries, each holding {valid, tag, data}.
  - One replacement pointer of width clog2(WAY), minimum 1 bit.
- Lookup (`en`=1, `wrt`=0):
  - Compare the tag against every valid way in the set.
  - On a hit, `o_data` = that way's data and `o_success` = 1.
  - On a miss, `o_data` = 0 and `o_success` = 0.
  - A lookup never changes cache state.
- Fill (`en`=1, `wrt`=1):
  - If the tag is already valid in the set, overwrite that way's data. The pointer does not move.
  - Otherwise, if any way is invalid, write the lowest-numbered invalid way. The pointer does not move.
  - Otherwise, evict the way named by the pointer, then advance the pointer by 1, wrapping from WAY-1 to 0. This is FIFO replacement.
  - A fill sets the way's valid bit and tag and writes `i_data`.
  - Fill response: `o_success` = 1, `o_data` = `i_data`.
- Idle (`en`=0): `o_success` = 0 and `o_data` holds its previous value.
- At most one tag can match within a set. The fill rule above guarantees this.
- `WAY` = 1: a direct-mapped cache. The pointer is constant 0, and a fill to a full set always replaces way 0.

## Timing
- One request per cycle. There is no back-pressure; every request is accepted.
- Latency is 1: inputs are sampled at rising edge N, and `o_data`/`o_success` are registered and valid immediately after edge N, holding until edge N+1.
- A fill at edge N is visible to a lookup sampled at edge N+1, with no bubble.
- Reset, when `rst`=1 at an edge:
  - All valid bits clear, and all pointers return to 0.
  - `o_data` = 0 and `o_success` = 0.
  - Tag and data storage need not be cleared.
  - Reset overrides any simultaneous `en`.
  - A request coincident with reset is dropped.
- After reset deasserts, every lookup misses until the set has been filled.
- A lookup and a fill cannot coincide; `wrt` selects exactly one.
- Tags are full width (BIT_TOTAL-BIT_INDEX bits). Addresses that differ only above bit BIT_INDEX-1 must never alias.

## Test plan
All scenarios use the defaults (SIZE_BLOCK=32, BIT_TOTAL=24, BIT_INDEX=5, WAY=3).
- **Reset then lookup:** reset 5 cycles, then look up 3 -> `o_success`=0, `o_data`=0.
- **Separate sets:** fill 3<-0xA, 4<-0xB, 5<-0xC, 0<-0xE, each followed by a lookup of the same address -> every lookup hits with `o_success`=1 and returns 0xA/0xB/0xC/0xE. Every fill cycle shows `o_success`=1 and echoes its data.
- **Filling set 0 to capacity:** fill 0, 32, 64 (set 0, data 0xE/0x1/0x2) -> all three hit afterwards.
- **FIFO eviction:** fill 96<-0x3 -> 96 hits 0x3 and 0 misses.
- **Re-fill of a present tag:** fill 64<-0x2 again -> the pointer does not move and 32 still hits.
- **Continued eviction:** fill 128<-0x4 -> 32 is evicted (misses) and 128 hits 0x4. Then fill 256<-0x8 -> 64 misses, and 96/128/256 all hit.
- **Idle and reset mid-stream:** with `en`=0 between requests, `o_success`=0 and `o_data` holds its last value. Assert `rst` with `en`=1 and `wrt`=1 -> the fill is dropped, all later lookups miss, and both outputs read 0.
- **`WAY`=1 (`cache_ro`):** fill 64<-0x2, then 96<-0x3 -> 64 misses and 96 hits.
